dii_packet_fifo: RTL and testbench
==================================

// Module: dii_packet_fifo
// PURPOSE
//  Circular-buffer DII flit FIFO of arbitrary depth with optional store-and-forward (full-packet) mode.
//  Sits between any DII producer and consumer (debug modules, ring routers, NoC adapters).
//  Reports occupancy, stored-packet count and head-packet length.
//  Avoids deadlock on packets longer than the buffer by switching to cut-through.
// PARAMETERS
//  BUF_SIZE    4  entries (flits); any integer >= 2, power of two not required
//  FULLPACKET  0  0: output any stored flit; 1: output only complete packets (DRAIN fallback)
//  CW          $clog2(BUF_SIZE+1)  derived, localparam; width of count outputs
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, synchronous, active-high
//  flit_in        in   dii_flit  {valid,last,data[15:0]} upstream flit
//  flit_in_ready  out  1      upstream may transfer
//  flit_out       out  dii_flit  head flit, first-word fall-through
//  flit_out_ready in   1      downstream accepts
//  occupancy      out  CW     stored flits, 0..BUF_SIZE
//  packet_count   out  CW     stored flits with last=1
//  packet_size    out  CW     head packet length incl. last flit; 0 if no last stored
//  cut_through    out  1      1 while in DRAIN state
// BEHAVIOUR
//  - Reset: wp=rp=0, occupancy=0, packet_count=0, state STORE; all outputs 0 (flit_out.valid=0,
//    packet_size=0, cut_through=0); flit_in_ready=0 while rst high; memory not reset.
//    Reset mid-packet discards all content, incl. partial packets; no flush handshake.
//  - push = flit_in.valid & flit_in_ready; pop = flit_out.valid & flit_out_ready.
//  - flit_in_ready = !rst & (occupancy != BUF_SIZE); no combinational path from flit_out_ready
//    (full + simultaneous pop still refuses input that cycle).
//  - push: mem[wp]<={last,data}; wp wraps BUF_SIZE-1 -> 0. pop: rp wraps likewise.
//  - occupancy: +1 on push only, -1 on pop only, unchanged on both/neither.
//  - packet_count: +1 on push with last, -1 on pop with last; both -> unchanged.
//  - flit_out.last/data = mem[rp] combinationally; undefined data allowed when valid=0.
//  - FULLPACKET=0: flit_out.valid = occupancy!=0. Latency: flit pushed at edge N valid after N.
//  - FULLPACKET=1, FSM {STORE, DRAIN}:
//    STORE: valid = occupancy!=0 & packet_count!=0.
//      -> DRAIN when occupancy==BUF_SIZE & packet_count==0 (registered values).
//    DRAIN: valid = occupancy!=0; cut_through=1. -> STORE on pop with last=1.
//    Latency STORE: head valid the cycle after the edge that stored its packet's last flit.
//  - packet_size: distance rp..first stored last=1 entry (scan over occupied entries only,
//    modulo wrap), +1; 0 if packet_count==0. Purely combinational from registers.
//    In DRAIN it reflects remaining flits of the partial packet once its last is stored.
//  - Flits with valid=0 are never stored; last on invalid flits ignored.
//  - All counters saturate-free by construction; assertions: no push when full, no pop when empty.
// STRUCTURE
//  - dii_package: reuse dii_flit, dii_flit_assemble; add typedef dii_fifo_state_t {STORE,DRAIN}.
//  - Sub-module dii_lastscan: inputs last-bit vector [BUF_SIZE], rp, occupancy; outputs
//    packet_size (rotate by rp, mask beyond occupancy, priority-encode lowest set bit).
//  - Storage: plain register array (no reset), wp/rp/count/pcount regs, FSM reg.
// TESTING
//  1. BUF_SIZE=4,FP=0: push A,B,C,D back-to-back, ready=0 -> occupancy 4, in_ready=0; pop 4 ->
//     A,B,C,D in order, occupancy 0, valid=0.
//  2. BUF_SIZE=5,FP=1: push 3-flit pkt (last on 3rd) -> valid=0 until cycle after 3rd push;
//     packet_size=3, packet_count=1; pop all -> packet_count 0.
//  3. BUF_SIZE=4,FP=1: 6-flit packet -> after 4 pushes cut_through=1, flits stream, input resumes;
//     after last popped cut_through=0.
//  4. Wrap: BUF_SIZE=3, 10 random packets with random ready throttling -> output equals input,
//     occupancy never >3, packet_size matches model each cycle.
//  5. Simultaneous push/pop at occupancy 2, last on both -> occupancy 2, packet_count unchanged.
//  6. rst asserted mid-packet with occupancy 3 -> next cycle occupancy 0, valid 0, in_ready 1
//     after rst drops; subsequent packet passes intact.

Source files
------------

// File: rtl/dii_packet_fifo_pkg.sv
// Shared DII flit type, flit helper and FIFO state encoding.
package dii_packet_fifo_pkg;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    typedef enum logic {
        STORE = 1'b0,
        DRAIN = 1'b1
    } dii_fifo_state_t;

    function automatic dii_flit dii_flit_assemble(input logic valid, input logic last,
                                                  input logic [15:0] data);
        dii_flit f;
        f.valid = valid;
        f.last  = last;
        f.data  = data;
        return f;
    endfunction

endpackage

// File: rtl/dii_packet_fifo_lastscan.sv
// Head-packet length finder: walks occupied entries from the read pointer
// and reports the distance to the first stored last flit, plus one.
module dii_packet_fifo_lastscan #(
    parameter  int BUF_SIZE = 4,
    localparam int CW       = $clog2(BUF_SIZE + 1),
    localparam int PW       = $clog2(BUF_SIZE)
) (
    input  logic [BUF_SIZE-1:0] last_vec,
    input  logic [PW-1:0]       rp,
    input  logic [CW-1:0]       occupancy,
    output logic [CW-1:0]       packet_size
);

    localparam int unsigned N       = BUF_SIZE;
    localparam logic [PW-1:0] LASTIDX = PW'(BUF_SIZE - 1);

    logic [PW-1:0] ptr;
    logic          found;

    // Rotate by rp, mask beyond occupancy, take the lowest set last bit.
    always_comb begin
        packet_size = '0;
        found       = 1'b0;
        ptr         = rp;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && (CW'(i) < occupancy) && last_vec[ptr]) begin
                packet_size = CW'(i + 1);
                found       = 1'b1;
            end
            ptr = (ptr == LASTIDX) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/dii_packet_fifo.sv
// Circular-buffer DII flit FIFO with optional store-and-forward mode.
// Store-and-forward falls back to cut-through (DRAIN) when the buffer fills
// without holding a complete packet, so oversize packets cannot deadlock.
module dii_packet_fifo
    import dii_packet_fifo_pkg::*;
#(
    parameter  int BUF_SIZE   = 4,
    parameter  bit FULLPACKET = 1'b0,
    localparam int CW         = $clog2(BUF_SIZE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  dii_flit       flit_in,
    output logic          flit_in_ready,
    output dii_flit       flit_out,
    input  logic          flit_out_ready,
    output logic [CW-1:0] occupancy,
    output logic [CW-1:0] packet_count,
    output logic [CW-1:0] packet_size,
    output logic          cut_through
);

    localparam int PW = $clog2(BUF_SIZE);
    localparam logic [CW-1:0] FULL    = CW'(BUF_SIZE);
    localparam logic [PW-1:0] LASTIDX = PW'(BUF_SIZE - 1);

    logic [16:0]           mem_q [BUF_SIZE];
    logic [BUF_SIZE-1:0]   last_vec;
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]         occ_q, occ_d, pcnt_q, pcnt_d;
    dii_fifo_state_t       state_q, state_d;
    logic                  push, pop, push_last, pop_last;

    for (genvar g = 0; g < BUF_SIZE; g++) begin : g_last
        assign last_vec[g] = mem_q[g][16];
    end

    dii_packet_fifo_lastscan #(.BUF_SIZE(BUF_SIZE)) u_lastscan (
        .last_vec    (last_vec),
        .rp          (rp_q),
        .occupancy   (occ_q),
        .packet_size (packet_size)
    );

    // Handshakes, head flit view and status outputs.
    always_comb begin
        flit_in_ready  = !rst && (occ_q != FULL);
        flit_out.last  = mem_q[rp_q][16];
        flit_out.data  = mem_q[rp_q][15:0];
        if (FULLPACKET && state_q == STORE)
            flit_out.valid = (occ_q != '0) && (pcnt_q != '0);
        else
            flit_out.valid = (occ_q != '0);
        push        = flit_in.valid && flit_in_ready;
        pop         = flit_out.valid && flit_out_ready;
        push_last   = push && flit_in.last;
        pop_last    = pop && flit_out.last;
        occupancy    = occ_q;
        packet_count = pcnt_q;
        cut_through  = (state_q == DRAIN);
    end

    // Next-state for pointers, counters and the STORE/DRAIN mode.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        occ_d   = occ_q;
        pcnt_d  = pcnt_q;
        state_d = state_q;
        if (push) wp_d = (wp_q == LASTIDX) ? '0 : wp_q + PW'(1);
        if (pop)  rp_d = (rp_q == LASTIDX) ? '0 : rp_q + PW'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
        case ({push_last, pop_last})
            2'b10:   pcnt_d = pcnt_q + CW'(1);
            2'b01:   pcnt_d = pcnt_q - CW'(1);
            default: pcnt_d = pcnt_q;
        endcase
        if (FULLPACKET) begin
            case (state_q)
                STORE:   if (occ_q == FULL && pcnt_q == '0) state_d = DRAIN;
                DRAIN:   if (pop_last) state_d = STORE;
                default: state_d = STORE;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
            pcnt_q  <= '0;
            state_q <= STORE;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            occ_q   <= occ_d;
            pcnt_q  <= pcnt_d;
            state_q <= state_d;
        end
    end

    // Flit storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {flit_in.last, flit_in.data};
    end

    // Handshake sanity: never push into a full or pop from an empty buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && occ_q == FULL));
            assert (!(pop && occ_q == '0));
        end
    end

endmodule

// File: tb/tb_dii_packet_fifo.sv
// Directed bench for dii_packet_fifo across four parameter configurations.
module tb_dii_packet_fifo;
    import dii_packet_fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    dii_flit fi0, fo0, fi1, fo1, fi2, fo2, fi3, fo3;
    logic ir0, ir1, ir2, ir3, or0, or1, or2, or3, ct0, ct1, ct2, ct3;
    logic [2:0] occ0, pc0, ps0, occ1, pc1, ps1, occ2, pc2, ps2;
    logic [1:0] occ3, pc3, ps3;

    int total = 0;
    int bad   = 0;

    dii_packet_fifo #(.BUF_SIZE(4), .FULLPACKET(1'b0)) u0 (
        .clk(clk), .rst(rst), .flit_in(fi0), .flit_in_ready(ir0), .flit_out(fo0),
        .flit_out_ready(or0), .occupancy(occ0), .packet_count(pc0), .packet_size(ps0),
        .cut_through(ct0));
    dii_packet_fifo #(.BUF_SIZE(5), .FULLPACKET(1'b1)) u1 (
        .clk(clk), .rst(rst), .flit_in(fi1), .flit_in_ready(ir1), .flit_out(fo1),
        .flit_out_ready(or1), .occupancy(occ1), .packet_count(pc1), .packet_size(ps1),
        .cut_through(ct1));
    dii_packet_fifo #(.BUF_SIZE(4), .FULLPACKET(1'b1)) u2 (
        .clk(clk), .rst(rst), .flit_in(fi2), .flit_in_ready(ir2), .flit_out(fo2),
        .flit_out_ready(or2), .occupancy(occ2), .packet_count(pc2), .packet_size(ps2),
        .cut_through(ct2));
    dii_packet_fifo #(.BUF_SIZE(3), .FULLPACKET(1'b0)) u3 (
        .clk(clk), .rst(rst), .flit_in(fi3), .flit_in_ready(ir3), .flit_out(fo3),
        .flit_out_ready(or3), .occupancy(occ3), .packet_count(pc3), .packet_size(ps3),
        .cut_through(ct3));

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned model_ps(input logic [16:0] q[$]);
        for (int i = 0; i < q.size(); i++)
            if (q[i][16]) return i + 1;
        return 0;
    endfunction

    logic [15:0] d4 [4] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
    logic [15:0] d6 [6] = '{16'h0100, 16'h0201, 16'h0302, 16'h0403, 16'h0504, 16'h0605};
    logic [16:0] src[$];
    logic [16:0] mq[$];

    initial begin
        int tx, rx, tx_at_ct, len;
        bit saw_ct, pop_w, push_w;

        rst = 1'b1;
        fi0 = '0; fi1 = '0; fi2 = '0; fi3 = '0;
        or0 = 1'b0; or1 = 1'b0; or2 = 1'b0; or3 = 1'b0;
        step(); step();
        check("rst_in_ready", ir0, 0);
        check("rst_occ", occ0, 0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", ir0, 1);
        check("post_rst_valid", fo0.valid, 0);
        check("post_rst_pcount", pc0, 0);
        check("post_rst_psize", ps0, 0);
        check("post_rst_cut", ct1, 0);

        // 1: fill BUF_SIZE=4, then drain in order
        for (int i = 0; i < 4; i++) begin
            fi0 = dii_flit_assemble(1'b1, i == 3, d4[i]);
            step();
        end
        fi0 = dii_flit_assemble(1'b1, 1'b0, 16'hEEEE);
        check("t1_occ_full", occ0, 4);
        check("t1_in_ready_full", ir0, 0);
        check("t1_pcount", pc0, 1);
        check("t1_psize", ps0, 4);
        step();
        fi0 = '0;
        check("t1_full_refuse", occ0, 4);
        or0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t1_pop_valid", fo0.valid, 1);
            check("t1_pop_data", fo0.data, d4[i]);
            step();
        end
        or0 = 1'b0;
        check("t1_occ_empty", occ0, 0);
        check("t1_valid_empty", fo0.valid, 0);

        // 5: simultaneous push/pop at occupancy 2, both last
        fi0 = dii_flit_assemble(1'b1, 1'b1, 16'h1111); step();
        fi0 = dii_flit_assemble(1'b1, 1'b1, 16'h2222); step();
        check("t5_occ2", occ0, 2);
        check("t5_pc2", pc0, 2);
        check("t5_ps1", ps0, 1);
        fi0 = dii_flit_assemble(1'b1, 1'b1, 16'h3333);
        or0 = 1'b1;
        step();
        fi0 = '0;
        check("t5_occ_same", occ0, 2);
        check("t5_pc_same", pc0, 2);
        check("t5_head", fo0.data, 16'h2222);
        step();
        check("t5_head2", fo0.data, 16'h3333);
        step();
        or0 = 1'b0;
        check("t5_drained", occ0, 0);

        // 6: reset mid-packet
        for (int i = 0; i < 3; i++) begin
            fi0 = dii_flit_assemble(1'b1, 1'b0, 16'(16'h4000 + i));
            step();
        end
        fi0 = '0;
        check("t6_occ3", occ0, 3);
        rst = 1'b1;
        step();
        check("t6_rst_occ", occ0, 0);
        check("t6_rst_valid", fo0.valid, 0);
        check("t6_rst_in_ready", ir0, 0);
        rst = 1'b0;
        #1;
        check("t6_in_ready", ir0, 1);
        for (int i = 0; i < 3; i++) begin
            fi0 = dii_flit_assemble(1'b1, i == 2, 16'(16'h5000 + i));
            step();
        end
        fi0 = '0;
        check("t6_occ", occ0, 3);
        check("t6_pc", pc0, 1);
        check("t6_ps", ps0, 3);
        or0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t6_data", fo0.data, 16'h5000 + i);
            check("t6_last", fo0.last, (i == 2) ? 1 : 0);
            step();
        end
        or0 = 1'b0;
        check("t6_empty", occ0, 0);

        // 2: store-and-forward, 3-flit packet in BUF_SIZE=5
        fi1 = dii_flit_assemble(1'b1, 1'b0, 16'h6000); step();
        check("t2_wait1", fo1.valid, 0);
        check("t2_occ1", occ1, 1);
        fi1 = dii_flit_assemble(1'b1, 1'b0, 16'h6001); step();
        check("t2_wait2", fo1.valid, 0);
        fi1 = dii_flit_assemble(1'b1, 1'b1, 16'h6002); step();
        fi1 = '0;
        check("t2_valid", fo1.valid, 1);
        check("t2_psize", ps1, 3);
        check("t2_pcount", pc1, 1);
        check("t2_cut", ct1, 0);
        or1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_data", fo1.data, 16'h6000 + i);
            step();
        end
        or1 = 1'b0;
        check("t2_pc0", pc1, 0);
        check("t2_occ0", occ1, 0);
        check("t2_valid0", fo1.valid, 0);

        // 3: oversize packet forces cut-through in BUF_SIZE=4
        tx = 0; rx = 0; saw_ct = 1'b0; tx_at_ct = -1;
        or2 = 1'b1;
        for (int cyc = 0; cyc < 100 && rx < 6; cyc++) begin
            if (ct2 && !saw_ct) begin
                saw_ct = 1'b1;
                tx_at_ct = tx;
            end
            if (fo2.valid) begin
                check("t3_data", fo2.data, d6[rx]);
                check("t3_last", fo2.last, (rx == 5) ? 1 : 0);
                rx++;
            end
            if (tx < 6) fi2 = dii_flit_assemble(1'b1, tx == 5, d6[tx]);
            else        fi2 = '0;
            if (fi2.valid && ir2) tx++;
            step();
        end
        fi2 = '0;
        or2 = 1'b0;
        check("t3_rx_all", rx, 6);
        check("t3_tx_all", tx, 6);
        check("t3_saw_cut", saw_ct, 1);
        check("t3_cut_when_full", tx_at_ct, 4);
        check("t3_cut_cleared", ct2, 0);
        check("t3_empty", occ2, 0);

        // 4: wrap with random packets and throttling in BUF_SIZE=3
        for (int p = 0; p < 10; p++) begin
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++)
                src.push_back({k == len - 1, 16'($urandom)});
        end
        tx = 0; rx = 0;
        for (int cyc = 0; cyc < 3000 && rx < src.size(); cyc++) begin
            check("t4_occ", occ3, mq.size());
            check("t4_psize", ps3, model_ps(mq));
            check("t4_in_ready", ir3, (mq.size() < 3) ? 1 : 0);
            if (mq.size() > 0) begin
                check("t4_valid", fo3.valid, 1);
                check("t4_head", {fo3.last, fo3.data}, mq[0]);
            end else begin
                check("t4_valid", fo3.valid, 0);
            end
            or3 = 1'($urandom_range(0, 1));
            pop_w = or3 && (mq.size() > 0);
            if (tx < src.size() && $urandom_range(0, 3) != 0)
                fi3 = dii_flit_assemble(1'b1, src[tx][16], src[tx][15:0]);
            else
                fi3 = dii_flit_assemble(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
            push_w = fi3.valid && (mq.size() < 3);
            if (pop_w) begin
                void'(mq.pop_front());
                rx++;
            end
            if (push_w) begin
                mq.push_back(src[tx]);
                tx++;
            end
            step();
        end
        fi3 = '0;
        or3 = 1'b0;
        check("t4_rx_all", rx, src.size());
        check("t4_empty", occ3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
